clock_time_ctrl: RTL and testbench
==================================

// Module: clock_time_ctrl
// PURPOSE
//  Controller that sequences the seconds/minutes/hours time-of-day datapath from a single system clock.
//  Contains an internal tick prescaler (NCO-style), cascaded 0..59 / 0..59 / 0..HOUR_MAX counters,
//  and a mode FSM that switches between free-running and manual time-setting via button pulses.
//  Sits between the debounced button logic and the display decoders; all logic on clk, no derived clocks.
// PARAMETERS
//  CLK_DIV   50_000_000  clk cycles per 1 s tick; legal range >= 2; prescaler width = $clog2(CLK_DIV)
//  HOUR_MAX  23          last hour value before wrap to 0 (23 = 24 h mode, 11 = 12 h mode)
// PORTS
//  clk         in   1  system clock, all state updates on rising edge
//  rst         in   1  asynchronous, active-high reset
//  run_en      in   1  1 = time advances in RUN; 0 = prescaler and time hold
//  mode_pulse  in   1  single-cycle pulse (pre-synchronised): advance mode FSM
//  inc_pulse   in   1  single-cycle pulse (pre-synchronised): increment field selected in SET_* state
//  sec         out  6  seconds 0..59
//  min         out  6  minutes 0..59
//  hour        out  5  hours 0..HOUR_MAX
//  tick        out  1  1-cycle strobe, high in the cycle after a prescaler wrap (when sec advanced)
//  day_pulse   out  1  1-cycle strobe, high when hour wraps HOUR_MAX->0 due to a tick carry
//  mode        out  2  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
// BEHAVIOUR
//  Reset: async, active-high; while rst=1, sec=min=hour=0, tick=day_pulse=0, mode=RUN, prescaler=0.
//  All outputs registered; reset mid-operation clears everything immediately, with no pending tick.
//  Prescaler: in RUN with run_en=1, increments each edge; at CLK_DIV-1 it wraps to 0 on the next edge,
//   and on that edge sec advances and tick<=1 (tick high exactly one cycle, coincident with new sec).
//   With run_en=1 from reset release, the first tick/sec update occurs on the CLK_DIV-th rising edge.
//  run_en=0 in RUN: prescaler and time hold their values; resuming continues from the held count.
//  Carry chain (RUN only): sec 59->0 increments min; min 59->0 increments hour; hour HOUR_MAX->0 sets
//   day_pulse for one cycle (same cycle as tick). Out-of-range values (>=59 / >=HOUR_MAX) wrap to 0.
//  FSM: RUN -mode_pulse-> SET_HOUR -mode_pulse-> SET_MIN -mode_pulse-> SET_SEC -mode_pulse-> RUN.
//   Transition is visible on mode in the cycle after the pulse edge.
//  In SET_* states: prescaler frozen, no tick/day_pulse, and run_en ignored.
//   SET_HOUR: inc_pulse hour = (hour==HOUR_MAX)?0:hour+1; no other field changes.
//   SET_MIN:  inc_pulse min  = (min==59)?0:min+1; no carry into hour.
//   SET_SEC:  inc_pulse sec  = (sec==59)?0:sec+1; no carry into min.
//  Leaving SET_SEC for RUN clears the prescaler to 0, so a full second elapses before the next tick.
//  In RUN, inc_pulse is ignored.
//  Simultaneous mode_pulse and inc_pulse: mode_pulse wins; the state advances and inc_pulse is dropped.
//  Simultaneous prescaler wrap and mode_pulse in RUN: the tick and carry are applied on that edge, and the
//   FSM moves to SET_HOUR on the same edge.
// TESTING  (bench uses CLK_DIV=4, HOUR_MAX=23)
//  1 rst 1->0, run_en=1 -> tick on edges 4, 8, 12; sec=1,2,3; min=hour=0; day_pulse never set
//  2 set time 23:59:58 via SET_* pulses, return to RUN -> after 8 edges time=00:00:00;
//    day_pulse=1 with the second tick only
//  3 SET_MIN with min=59, inc_pulse -> min=0, hour unchanged; 4 mode_pulses from RUN -> mode 1,2,3,0
//  4 RUN, prescaler=2, run_en=0 for 10 cycles -> no tick, sec held; run_en=1 -> tick on 2nd enabled edge
//  5 SET_HOUR hour=5, mode_pulse+inc_pulse same cycle -> mode=SET_MIN, hour=5
//  6 rst asserted mid-count at 00:00:37 -> outputs 0 and mode=RUN without waiting for clk;
//    release -> first tick after 4 edges

Source files
------------

// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: 1 s tick prescaler, cascaded sec/min/hour counters
// and a RUN/SET_HOUR/SET_MIN/SET_SEC mode FSM driven by debounced button pulses.
// Everything runs on clk; the tick is a clock-enable, never a derived clock.
module clock_time_ctrl #(
    parameter int CLK_DIV  = 50_000_000,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       tick,
    output logic       day_pulse,
    output logic [1:0] mode
);

    localparam int              PS_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CLK_DIV - 1);
    localparam logic [4:0]      HOUR_LAST = 5'(HOUR_MAX);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    mode_t           state;
    mode_t           state_next;
    logic [PS_W-1:0] prescaler;
    logic            running;
    logic            wrap;
    logic            sec_carry;
    logic            min_carry;
    logic            hour_carry;

    // Time only advances in RUN with run_en; a wrap is the last prescaler count
    assign running    = (state == RUN) && run_en;
    assign wrap       = running && (prescaler == PS_LAST);
    assign sec_carry  = (sec >= 6'd59);
    assign min_carry  = (min >= 6'd59);
    assign hour_carry = (hour >= HOUR_LAST);

    assign mode = state;

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Each mode_pulse steps the FSM round the RUN -> SET_* ring
    always_comb begin
        state_next = state;
        if (mode_pulse) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                SET_SEC:  state_next = RUN;
                default:  state_next = RUN;
            endcase
        end
    end

    // Prescaler counts in RUN, freezes in SET_*, and restarts on leaving SET_SEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (running) begin
            prescaler <= wrap ? '0 : prescaler + PS_W'(1);
        end else if ((state == SET_SEC) && mode_pulse) begin
            prescaler <= '0;
        end
    end

    // Time fields: carry chain on a wrap in RUN, single-field increments in SET_*
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            tick      <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            tick      <= wrap;
            day_pulse <= wrap && sec_carry && min_carry && hour_carry;
            if (wrap) begin
                sec <= sec_carry ? 6'd0 : sec + 6'd1;
                if (sec_carry) begin
                    min <= min_carry ? 6'd0 : min + 6'd1;
                    if (min_carry) begin
                        hour <= hour_carry ? 5'd0 : hour + 5'd1;
                    end
                end
            end else if (inc_pulse && !mode_pulse) begin
                case (state)
                    SET_HOUR: hour <= hour_carry ? 5'd0 : hour + 5'd1;
                    SET_MIN:  min  <= min_carry  ? 6'd0 : min + 6'd1;
                    SET_SEC:  sec  <= sec_carry  ? 6'd0 : sec + 6'd1;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: the stimulus process steps a
// seconds-of-day reference model and queues the expected outputs; a monitor
// pops one entry after every clock edge and compares it with the DUT.
module tb_clock_time_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int HOUR_MAX = 23;
    localparam int DAY_SECS = (HOUR_MAX + 1) * 3600;

    typedef struct packed {
        logic [1:0] mode;
        logic       tick;
        logic       day;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       run_en;
    logic       mode_pulse;
    logic       inc_pulse;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;
    logic       day_pulse;
    logic [1:0] mode;

    int   compared   = 0;
    int   mismatched = 0;
    int   cycle_no   = 0;
    obs_t sb[$];

    // Reference model state: time as seconds since midnight, mode as 0..3
    int m_tod;
    int m_mode;
    int m_pre;

    clock_time_ctrl #(
        .CLK_DIV (CLK_DIV),
        .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_en    (run_en),
        .mode_pulse(mode_pulse),
        .inc_pulse (inc_pulse),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .tick      (tick),
        .day_pulse (day_pulse),
        .mode      (mode)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int hourOf();
        return m_tod / 3600;
    endfunction

    function automatic int minOf();
        return (m_tod / 60) % 60;
    endfunction

    function automatic int secOf();
        return m_tod % 60;
    endfunction

    // Compare the DUT outputs against one expected snapshot
    task automatic checkOutput(input string name, input obs_t expv);
        obs_t act;
        act.mode = mode;
        act.tick = tick;
        act.day  = day_pulse;
        act.hour = hour;
        act.min  = min;
        act.sec  = sec;
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got mode=%0d tick=%0b day=%0b %0d:%0d:%0d, expected mode=%0d tick=%0b day=%0b %0d:%0d:%0d",
                     name, act.mode, act.tick, act.day, act.hour, act.min, act.sec,
                     expv.mode, expv.tick, expv.day, expv.hour, expv.min, expv.sec);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the coming edge, queue the result
    task automatic applyStimulus(input logic r, input logic mp, input logic ip);
        obs_t e;
        int   h, m, s;
        @(posedge clk);
        #2;
        run_en     = r;
        mode_pulse = mp;
        inc_pulse  = ip;
        e.tick = 1'b0;
        e.day  = 1'b0;
        if (m_mode == 0) begin
            if (r) begin
                if (m_pre == CLK_DIV - 1) begin
                    m_pre  = 0;
                    e.tick = 1'b1;
                    m_tod  = m_tod + 1;
                    if (m_tod == DAY_SECS) begin
                        m_tod = 0;
                        e.day = 1'b1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (mp) m_mode = 1;
        end else if (mp) begin
            if (m_mode == 3) m_pre = 0;
            m_mode = (m_mode + 1) % 4;
        end else if (ip) begin
            h = hourOf();
            m = minOf();
            s = secOf();
            if (m_mode == 1) h = (h == HOUR_MAX) ? 0 : h + 1;
            if (m_mode == 2) m = (m + 1) % 60;
            if (m_mode == 3) s = (s + 1) % 60;
            m_tod = h * 3600 + m * 60 + s;
        end
        e.mode = 2'(m_mode);
        e.hour = 5'(hourOf());
        e.min  = 6'(minOf());
        e.sec  = 6'(secOf());
        sb.push_back(e);
    endtask

    // Assert reset between edges, check it acts without a clock, then release
    task automatic doReset();
        obs_t zero;
        zero = '0;
        @(posedge clk);
        #4;
        run_en     = 1'b0;
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        rst        = 1'b1;
        #1;
        checkOutput("async_reset", zero);
        m_tod  = 0;
        m_mode = 0;
        m_pre  = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Walk through the SET_* states from RUN to load h:m:s, then return to RUN
    task automatic setTime(input int h, input int m, input int s);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && hourOf() != h; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70 && minOf() != m; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 70 && secOf() != s; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: one expected snapshot per clock edge while stimulus is active
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                cycle_no++;
                checkOutput($sformatf("edge%0d", cycle_no), sb.pop_front());
            end
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        rst        = 1'b1;
        run_en     = 1'b0;
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        m_tod      = 0;
        m_mode     = 0;
        m_pre      = 0;
        doReset();

        $display("[TB] free run from reset");
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] midnight rollover");
        setTime(23, 59, 58);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] SET_MIN wrap and mode ring");
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 70 && minOf() != 59; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] run_en hold");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] mode_pulse beats inc_pulse");
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && hourOf() != 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] wrap coincident with mode_pulse");
        while (m_pre != CLK_DIV - 1) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] reset mid-count");
        setTime(0, 0, 37);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        doReset();
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
        end

        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
